wb_mem_arbiter2: RTL and testbench

Two-master WISHBONE arbiter that shares one 8 x 32-bit single-port block-RAM memory slave between two requesters (M0, M1).
- The slave's ACK timing is fixed: writes are acknowledged in the same cycle as STB; reads are acknowledged one cycle after STB.
- Arbitration is round-robin. A grant is held for the winner's whole CYC.
- A watchdog aborts a granted master whose strobe goes unacknowledged, so a hung transfer cannot lock the memory.
- Sits between the bus masters and the memory slave.

---
 rtl/wb_mem_arbiter2_if.sv | 30 +++
 rtl/wb_mem_arbiter2.sv | 65 ++++++
 tb/tb_wb_mem_arbiter2.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/wb_mem_arbiter2_if.sv
// wb_mem_arbiter2_if: both master ports and the memory port of the two-master arbiter.
// slave is the arbiter's view; master is the view of the masters and memory around it.
interface wb_mem_arbiter2_if;
  logic        M0_CYC_I, M0_STB_I, M0_WE_I;
  logic [2:0]  M0_ADR_I;
  logic [31:0] M0_DAT_I, M0_DAT_O;
  logic        M0_ACK_O, M0_ERR_O;
  logic        M1_CYC_I, M1_STB_I, M1_WE_I;
  logic [2:0]  M1_ADR_I;
  logic [31:0] M1_DAT_I, M1_DAT_O;
  logic        M1_ACK_O, M1_ERR_O;
  logic        S_STB_O, S_WE_O;
  logic [2:0]  S_ADR_O;
  logic [31:0] S_DAT_O, S_DAT_I;
  logic        S_ACK_I;
  modport slave (
    input  M0_CYC_I, M0_STB_I, M0_WE_I, M0_ADR_I, M0_DAT_I,
    input  M1_CYC_I, M1_STB_I, M1_WE_I, M1_ADR_I, M1_DAT_I,
    input  S_DAT_I, S_ACK_I,
    output M0_DAT_O, M0_ACK_O, M0_ERR_O, M1_DAT_O, M1_ACK_O, M1_ERR_O,
    output S_STB_O, S_WE_O, S_ADR_O, S_DAT_O
  );
  modport master (
    output M0_CYC_I, M0_STB_I, M0_WE_I, M0_ADR_I, M0_DAT_I,
    output M1_CYC_I, M1_STB_I, M1_WE_I, M1_ADR_I, M1_DAT_I,
    output S_DAT_I, S_ACK_I,
    input  M0_DAT_O, M0_ACK_O, M0_ERR_O, M1_DAT_O, M1_ACK_O, M1_ERR_O,
    input  S_STB_O, S_WE_O, S_ADR_O, S_DAT_O
  );
endinterface

// File: rtl/wb_mem_arbiter2.sv
// wb_mem_arbiter2: round-robin two-master WISHBONE arbiter with a strobe watchdog in front of one memory slave.
module wb_mem_arbiter2 #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  wb_mem_arbiter2_if.slave  bus,
  output logic [1:0]        GNT_O
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  state_t            state, state_nxt;
  logic              ptr, ptr_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              act, sel, m_cyc, m_stb, m_we, abort, s_stb;
  logic [2:0]        m_adr;
  logic [31:0]       m_dat;
  assign act   = state != IDLE;
  assign sel   = state == GRANT1;
  assign m_cyc = sel ? bus.M1_CYC_I : bus.M0_CYC_I;
  assign m_stb = sel ? bus.M1_STB_I : bus.M0_STB_I;
  assign m_we  = sel ? bus.M1_WE_I  : bus.M0_WE_I;
  assign m_adr = sel ? bus.M1_ADR_I : bus.M0_ADR_I;
  assign m_dat = sel ? bus.M1_DAT_I : bus.M0_DAT_I;
  assign abort = act && cnt == CNT_W'(TIMEOUT) && m_stb && !bus.S_ACK_I;
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state <= IDLE;
      ptr   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end
  // ptr=0 favours M0; leaving a grant hands priority to the other master
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = (act && m_stb && !bus.S_ACK_I) ? cnt + 1'b1 : '0;
    if (state == IDLE)
      state_nxt = (bus.M0_CYC_I && (!bus.M1_CYC_I || !ptr)) ? GRANT0 :
                  bus.M1_CYC_I ? GRANT1 : IDLE;
    else if (abort || !m_cyc) begin
      state_nxt = IDLE;
      ptr_nxt   = !sel;
      cnt_nxt   = '0;
    end
  end
  always_comb begin
    s_stb        = act && m_stb && m_cyc && !abort;
    bus.S_STB_O  = s_stb;
    bus.S_WE_O   = s_stb && m_we;
    bus.S_ADR_O  = s_stb ? m_adr : '0;
    bus.S_DAT_O  = s_stb ? m_dat : '0;
    bus.M0_ACK_O = state == GRANT0 && bus.S_ACK_I;
    bus.M1_ACK_O = state == GRANT1 && bus.S_ACK_I;
    bus.M0_ERR_O = state == GRANT0 && abort;
    bus.M1_ERR_O = state == GRANT1 && abort;
    bus.M0_DAT_O = bus.S_DAT_I;
    bus.M1_DAT_O = bus.S_DAT_I;
    GNT_O        = {sel, state == GRANT0};
  end
endmodule

// File: tb/tb_wb_mem_arbiter2.sv
// tb_wb_mem_arbiter2: directed vectors against a small 8x32 memory with same-cycle write ack and one-cycle read ack.
module tb_wb_mem_arbiter2;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  gnt;
  logic        ack_en;
  logic        rd_ack;
  logic        wr_req;
  logic [31:0] rd_dat;
  logic [31:0] mem [8];
  int          n_vec = 0;
  int          n_err = 0;
  wb_mem_arbiter2_if bus ();
  wb_mem_arbiter2 #(.TIMEOUT(15), .CNT_W(4)) dut (
    .CLK_I(clk),
    .RST_I(rst),
    .bus(bus),
    .GNT_O(gnt)
  );
  always #5 clk = ~clk;
  // write ack is decoded from the granted master's request so it is not looped through S_STB_O
  assign wr_req = (gnt[0] & bus.M0_CYC_I & bus.M0_STB_I & bus.M0_WE_I) |
                  (gnt[1] & bus.M1_CYC_I & bus.M1_STB_I & bus.M1_WE_I);
  assign bus.S_ACK_I = rd_ack | (ack_en & wr_req);
  assign bus.S_DAT_I = rd_dat;
  always_ff @(posedge clk) begin
    if (bus.S_STB_O && bus.S_WE_O) mem[bus.S_ADR_O] <= bus.S_DAT_O;
    rd_ack <= ack_en & bus.S_STB_O & ~bus.S_WE_O & ~rd_ack;
    rd_dat <= mem[bus.S_ADR_O];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [3:0] flags();
    return {bus.M0_ACK_O, bus.M0_ERR_O, bus.M1_ACK_O, bus.M1_ERR_O};
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    ack_en = 1'b1;
    rd_ack = 1'b0;
    rst = 1'b1;
    bus.M0_CYC_I = 1'b1; bus.M0_STB_I = 1'b0; bus.M0_WE_I = 1'b0; bus.M0_ADR_I = '0; bus.M0_DAT_I = '0;
    bus.M1_CYC_I = 1'b1; bus.M1_STB_I = 1'b0; bus.M1_WE_I = 1'b0; bus.M1_ADR_I = '0; bus.M1_DAT_I = '0;
    step();
    step();
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_stb", 32'(bus.S_STB_O), 32'h0);
    check("rst_flags", 32'(flags()), 32'h0);
    check("rst_adr", 32'(bus.S_ADR_O), 32'h0);
    rst = 1'b0;
    // first grant goes to M0; single write then read-back of ADR 3
    step();
    bus.M0_STB_I = 1'b1; bus.M0_WE_I = 1'b1; bus.M0_ADR_I = 3'd3; bus.M0_DAT_I = 32'hDEADBEEF;
    @(negedge clk);
    check("first_gnt", 32'(gnt), 32'h1);
    check("wr_stb", 32'(bus.S_STB_O), 32'h1);
    check("wr_ack", 32'(flags()), 32'b1000);
    check("wr_adr", 32'(bus.S_ADR_O), 32'h3);
    check("wr_dat", bus.S_DAT_O, 32'hDEADBEEF);
    step();
    bus.M0_WE_I = 1'b0;
    @(negedge clk);
    check("rd_stb", 32'(bus.S_STB_O), 32'h1);
    check("rd_we", 32'(bus.S_WE_O), 32'h0);
    check("rd_noack", 32'(flags()), 32'h0);
    step();
    @(negedge clk);
    check("rd_ack", 32'(flags()), 32'b1000);
    check("rd_dat", bus.M0_DAT_O, 32'hDEADBEEF);
    step();
    bus.M0_STB_I = 1'b0; bus.M0_CYC_I = 1'b0;
    @(negedge clk);
    check("drop_stb", 32'(bus.S_STB_O), 32'h0);
    step();
    @(negedge clk);
    check("idle_gap", 32'(gnt), 32'h0);
    step();
    @(negedge clk);
    check("rr_m1", 32'(gnt), 32'h2);
    bus.M1_CYC_I = 1'b0; bus.M0_CYC_I = 1'b1;
    step();
    bus.M1_CYC_I = 1'b1;
    @(negedge clk);
    check("idle_gap2", 32'(gnt), 32'h0);
    step();
    @(negedge clk);
    check("rr_both_m0", 32'(gnt), 32'h1);
    // M0 write burst while M1 keeps requesting
    for (int i = 0; i < 4; i++) begin
      step();
      bus.M0_STB_I = 1'b1; bus.M0_WE_I = 1'b1; bus.M0_ADR_I = 3'(i); bus.M0_DAT_I = 32'(i + 1) * 32'h11111111;
      @(negedge clk);
      check("burst_flags", 32'(flags()), 32'b1000);
      check("burst_gnt", 32'(gnt), 32'h1);
    end
    step();
    bus.M0_STB_I = 1'b0; bus.M0_CYC_I = 1'b0; bus.M0_WE_I = 1'b0;
    @(negedge clk);
    check("burst_end_gnt", 32'(gnt), 32'h1);
    check("burst_end_m1ack", 32'(bus.M1_ACK_O), 32'h0);
    step();
    @(negedge clk);
    check("burst_idle", 32'(gnt), 32'h0);
    step();
    @(negedge clk);
    check("m1_after_burst", 32'(gnt), 32'h2);
    for (int i = 0; i < 4; i++) begin
      step();
      bus.M1_STB_I = 1'b1; bus.M1_WE_I = 1'b0; bus.M1_ADR_I = 3'(i);
      @(negedge clk);
      check("m1_rd_wait", 32'(flags()), 32'h0);
      step();
      @(negedge clk);
      check("m1_rd_ack", 32'(flags()), 32'b0010);
      check("m1_rd_dat", bus.M1_DAT_O, 32'(i + 1) * 32'h11111111);
    end
    // reset during a pending M1 read while M1 holds priority
    step();
    bus.M1_ADR_I = 3'd5; bus.M0_CYC_I = 1'b1;
    @(negedge clk);
    check("pre_rst_gnt", 32'(gnt), 32'h2);
    check("pre_rst_stb", 32'(bus.S_STB_O), 32'h1);
    rst = 1'b1;
    step();
    @(negedge clk);
    check("midrst_gnt", 32'(gnt), 32'h0);
    check("midrst_stb", 32'(bus.S_STB_O), 32'h0);
    check("midrst_flags", 32'(flags()), 32'h0);
    rst = 1'b0;
    step();
    @(negedge clk);
    check("rst_ptr_m0", 32'(gnt), 32'h1);
    // watchdog: memory never acks, M1 holds STB from its first grant cycle
    bus.M0_CYC_I = 1'b0;
    ack_en = 1'b0;
    step();
    @(negedge clk);
    check("wd_idle", 32'(gnt), 32'h0);
    for (int k = 0; k <= 16; k++) begin
      step();
      @(negedge clk);
      check($sformatf("wd_err_k%0d", k), 32'(bus.M1_ERR_O), 32'(k == 15));
      check($sformatf("wd_stb_k%0d", k), 32'(bus.S_STB_O), 32'(k < 15));
      check($sformatf("wd_gnt_k%0d", k), 32'(gnt), (k <= 15) ? 32'h2 : 32'h0);
      check($sformatf("wd_m0_k%0d", k), 32'(flags()), (k == 15) ? 32'b0001 : 32'h0);
    end
    bus.M1_CYC_I = 1'b0; bus.M1_STB_I = 1'b0;
    ack_en = 1'b1;
    step();
    step();
    @(negedge clk);
    check("final_idle", 32'(gnt), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
